// File: rtl/lane_sync_pkg.sv
// ============================================================================
// Module : lane_sync_pkg
// Brief  : Shared symbol defaults and state encoding for the lane sync block
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lane_sync_pkg;

    localparam logic [7:0] DEF_COM_SYM  = 8'hBC;
    localparam logic [7:0] DEF_IDLE_SYM = 8'h7C;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } lane_state_t;

endpackage

`default_nettype wire

// File: rtl/lane_sync_shreg.sv
// ============================================================================
// Module : lane_sync_shreg
// Brief  : 8-bit MSB-first serial shift register with COM/IDLE comparators
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lane_sync_shreg
    import lane_sync_pkg::*;
#(
    parameter logic [7:0] COM_SYM  = DEF_COM_SYM,
    parameter logic [7:0] IDLE_SYM = DEF_IDLE_SYM
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] sr,
    output logic       is_com,
    output logic       is_idle
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= 8'd0;
        end else begin
            sr <= {sr[6:0], din};
        end
    end

    assign is_com  = (sr == COM_SYM);
    assign is_idle = (sr == IDLE_SYM);

endmodule

`default_nettype wire

// File: rtl/lane_sync_ctrl.sv
// ============================================================================
// Module : lane_sync_ctrl
// Brief  : Serial lane byte-phase alignment, lock tracking and byte delivery
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lane_sync_ctrl
    import lane_sync_pkg::*;
#(
    parameter logic [7:0] COM_SYM    = DEF_COM_SYM,
    parameter logic [7:0] IDLE_SYM   = DEF_IDLE_SYM,
    parameter int         LOCK_COUNT = 4,
    parameter int         MAX_GAP    = 16
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       byte_valid,
    output logic       active,
    output logic       IDL,
    output logic [1:0] state
);

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
    localparam logic [7:0] GAP_LAST  = 8'(MAX_GAP - 1);

    logic [7:0]  sr;
    logic        is_com;
    logic        is_idle;
    logic        boundary;

    lane_state_t state_r,    state_nxt;
    logic [2:0]  bit_cnt_r,  bit_cnt_nxt;
    logic [3:0]  com_cnt_r,  com_cnt_nxt;
    logic [7:0]  gap_cnt_r,  gap_cnt_nxt;
    logic [7:0]  data_r,     data_nxt;
    logic        valid_r,    valid_nxt;
    logic        active_r,   active_nxt;
    logic        idl_r,      idl_nxt;

    lane_sync_shreg #(
        .COM_SYM  (COM_SYM),
        .IDLE_SYM (IDLE_SYM)
    ) u_shreg (
        .clk     (clk_32f),
        .rst     (reset),
        .din     (data_in),
        .sr      (sr),
        .is_com  (is_com),
        .is_idle (is_idle)
    );

    assign boundary = (bit_cnt_r == 3'd0);

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_r   <= ST_SEARCH;
            bit_cnt_r <= 3'd0;
            com_cnt_r <= 4'd0;
            gap_cnt_r <= 8'd0;
            data_r    <= 8'd0;
            valid_r   <= 1'b0;
            active_r  <= 1'b0;
            idl_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            bit_cnt_r <= bit_cnt_nxt;
            com_cnt_r <= com_cnt_nxt;
            gap_cnt_r <= gap_cnt_nxt;
            data_r    <= data_nxt;
            valid_r   <= valid_nxt;
            active_r  <= active_nxt;
            idl_r     <= idl_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_r;
        bit_cnt_nxt = bit_cnt_r;
        com_cnt_nxt = com_cnt_r;
        gap_cnt_nxt = gap_cnt_r;
        data_nxt    = data_r;
        valid_nxt   = 1'b0;
        active_nxt  = active_r;
        idl_nxt     = idl_r;

        if (state_r != ST_SEARCH) begin
            bit_cnt_nxt = bit_cnt_r + 3'd1;
        end

        case (state_r)
            ST_SEARCH: begin
                // The matching cycle is itself the byte boundary, so the next one is 8 away
                if (is_com) begin
                    bit_cnt_nxt = 3'd1;
                    com_cnt_nxt = 4'd1;
                    state_nxt   = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_nxt = com_cnt_r + 4'd1;
                        if (com_cnt_r == LOCK_LAST) begin
                            state_nxt   = ST_ACTIVE;
                            active_nxt  = 1'b1;
                            gap_cnt_nxt = 8'd0;
                        end
                    end else begin
                        state_nxt   = ST_SEARCH;
                        com_cnt_nxt = 4'd0;
                    end
                end
            end
            ST_ACTIVE: begin
                if (boundary) begin
                    // Loss of lock wins over delivery: the offending byte is dropped
                    if (!is_com && (gap_cnt_r == GAP_LAST)) begin
                        state_nxt   = ST_SEARCH;
                        active_nxt  = 1'b0;
                        idl_nxt     = 1'b0;
                        com_cnt_nxt = 4'd0;
                    end else begin
                        data_nxt    = sr;
                        valid_nxt   = 1'b1;
                        idl_nxt     = is_idle;
                        gap_cnt_nxt = is_com ? 8'd0 : gap_cnt_r + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_SEARCH;
            end
        endcase
    end

    assign data_out   = data_r;
    assign byte_valid = valid_r;
    assign active     = active_r;
    assign IDL        = idl_r;
    assign state      = state_r;

endmodule

`default_nettype wire

// File: tb/tb_lane_sync_ctrl.sv
// ============================================================================
// Module : tb_lane_sync_ctrl
// Brief  : Self-checking bench for lane_sync_ctrl with a delivered-byte scoreboard
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_lane_sync_ctrl;

    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] IDLE = 8'h7C;
    localparam logic [7:0] PAY  = 8'h55;
    localparam int S_SEARCH = 0;
    localparam int S_ALIGN  = 1;
    localparam int S_ACTIVE = 2;

    logic       clk_32f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       byte_valid;
    logic       active;
    logic       IDL;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entry: {expected IDL, expected byte}
    logic [8:0] sb_q[$];

    lane_sync_ctrl u_dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .data_out   (data_out),
        .byte_valid (byte_valid),
        .active     (active),
        .IDL        (IDL),
        .state      (state)
    );

    initial begin
        clk_32f = 1'b0;
        forever #5 clk_32f = ~clk_32f;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int hi);
        for (int i = hi; i >= 0; i--) tick(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 7);
    endtask

    task automatic send_exp(input logic [7:0] b);
        send_byte(b);
        sb_q.push_back({(b == IDLE), b});
    endtask

    always @(posedge clk_32f) begin
        logic [8:0] e;
        #2;
        if (byte_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_strobe", 32'(byte_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_data", 32'(data_out), 32'(e[7:0]));
                check("sb_idl", 32'(IDL), 32'(e[8]));
            end
        end
    end

    initial begin
        reset   = 1'b1;
        data_in = 1'b0;
        repeat (3) @(posedge clk_32f);
        #1;
        check("rst_state", 32'(state), 32'(S_SEARCH));
        check("rst_active", 32'(active), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_idl", 32'(IDL), 32'd0);
        reset = 1'b0;

        // Lock-in with a 3-bit phase offset
        tick(1'b1); tick(1'b0); tick(1'b1);
        send_byte(COM);                                   // t0
        check("t0_still_search", 32'(state), 32'(S_SEARCH));
        tick(COM[7]);                                     // t0+1
        check("t0p1_align", 32'(state), 32'(S_ALIGN));
        send_bits(COM, 6);                                // t0+8
        send_byte(COM);                                   // t0+16
        send_byte(COM);                                   // t0+24
        check("t0p24_not_active", 32'(active), 32'd0);
        tick(PAY[7]);                                     // t0+25
        check("t0p25_active", 32'(active), 32'd1);
        check("t0p25_state", 32'(state), 32'(S_ACTIVE));
        send_bits(PAY, 6);                                // t0+32
        sb_q.push_back({1'b0, PAY});
        check("t0p32_no_strobe", 32'(byte_valid), 32'd0);
        tick(IDLE[7]);                                    // t0+33
        check("t0p33_strobe", 32'(byte_valid), 32'd1);
        check("t0p33_data", 32'(data_out), 32'(PAY));
        send_bits(IDLE, 6);
        sb_q.push_back({1'b1, IDLE});

        // Idle flagging
        send_exp(IDLE);
        send_exp(PAY);

        // Gap handling: a COM after 15 payload bytes keeps the lock
        send_exp(COM);
        for (int i = 0; i < 15; i++) send_exp(PAY);
        send_exp(COM);
        tick(1'b0);
        check("gap_com_keeps_lock", 32'(active), 32'd1);
        send_bits(PAY, 6);
        sb_q.push_back({1'b0, PAY});
        for (int i = 0; i < 14; i++) send_exp(PAY);
        send_byte(PAY);                                   // 16th non-COM: dropped
        tick(1'b0);
        check("lol_active", 32'(active), 32'd0);
        check("lol_state", 32'(state), 32'(S_SEARCH));
        check("lol_no_strobe", 32'(byte_valid), 32'd0);
        check("lol_data_hold", 32'(data_out), 32'(PAY));
        send_byte(8'h00);

        // Failed alignment: three COMs then a non-COM
        send_byte(COM);                                   // t0
        send_byte(COM);
        send_byte(COM);
        send_byte(8'h00);                                 // t0+24
        check("fail_t0p24_align", 32'(state), 32'(S_ALIGN));
        tick(1'b0);                                       // t0+25
        check("fail_t0p25_search", 32'(state), 32'(S_SEARCH));
        check("fail_no_active", 32'(active), 32'd0);
        send_bits(8'h00, 6);

        // Near-miss patterns; 0xBD/0xBE contain no COM at any bit offset
        // (0x5E followed by a zero bit would alias to COM one bit later)
        for (int i = 0; i < 6; i++) begin
            send_byte(8'hBD);
            send_byte(8'hBE);
            check("false_phase_search", 32'(state), 32'(S_SEARCH));
        end
        send_byte(COM);                                   // t0
        tick(COM[7]);
        check("aligned_com_align", 32'(state), 32'(S_ALIGN));
        send_bits(COM, 6);
        send_byte(COM);
        send_byte(COM);
        tick(1'b1);                                       // t0+25
        check("relock_active", 32'(active), 32'd1);
        tick(1'b0); tick(1'b1);

        // Asynchronous reset mid-byte while locked
        #3 reset = 1'b1;
        #1;
        check("rst_mid_active", 32'(active), 32'd0);
        check("rst_mid_state", 32'(state), 32'(S_SEARCH));
        check("rst_mid_data", 32'(data_out), 32'd0);
        check("rst_mid_valid", 32'(byte_valid), 32'd0);
        @(posedge clk_32f);
        #1 reset = 1'b0;

        send_byte(COM);
        send_byte(COM);
        send_byte(COM);
        check("post_rst_align", 32'(state), 32'(S_ALIGN));
        send_byte(COM);
        check("post_rst_3com_inactive", 32'(active), 32'd0);
        tick(1'b1);
        check("post_rst_4com_active", 32'(active), 32'd1);
        send_bits(8'hA5, 6);
        sb_q.push_back({1'b0, 8'hA5});
        send_byte(8'h00);
        sb_q.push_back({1'b0, 8'h00});
        repeat (4) tick(1'b0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
